// File: rtl/student_mux_arbiter8.sv
// rtl/student_mux_arbiter8.sv - round-robin 8-requester arbiter sharing one 16-bit bus via student_mux8way16
// Optional BURST_LOCK_EN: a granted requester holding lock keeps the bus across transfers.

module student_nand (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = ~(a & b);
endmodule

module student_not (
   input  logic a,
   output logic y
);
   student_nand u_nand (.a(a), .b(a), .y(y));
endmodule

module student_and (
   input  logic a,
   input  logic b,
   output logic y
);
   logic n;
   student_nand u_nand (.a(a), .b(b), .y(n));
   student_not  u_not  (.a(n), .y(y));
endmodule

module student_or (
   input  logic a,
   input  logic b,
   output logic y
);
   logic na, nb;
   student_not  u_na   (.a(a), .y(na));
   student_not  u_nb   (.a(b), .y(nb));
   student_nand u_nand (.a(na), .b(nb), .y(y));
endmodule

module student_mux (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);
   logic nsel, pa, pb;
   student_not u_nsel (.a(sel), .y(nsel));
   student_and u_pa   (.a(a), .b(nsel), .y(pa));
   student_and u_pb   (.a(b), .b(sel), .y(pb));
   student_or  u_or   (.a(pa), .b(pb), .y(y));
endmodule

module student_mux16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sel,
   output logic [15:0] y
);
   for (genvar i = 0; i < 16; i++) begin : g_bit
      student_mux u_mux (.a(a[i]), .b(b[i]), .sel(sel), .y(y[i]));
   end
endmodule

module student_and16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);
   for (genvar i = 0; i < 16; i++) begin : g_bit
      student_and u_and (.a(a[i]), .b(b[i]), .y(y[i]));
   end
endmodule

module student_mux8way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] y
);
   logic [15:0] ab, cd, ef, gh, abcd, efgh;
   student_mux16 u_ab   (.a(a),    .b(b),    .sel(sel[0]), .y(ab));
   student_mux16 u_cd   (.a(c),    .b(d),    .sel(sel[0]), .y(cd));
   student_mux16 u_ef   (.a(e),    .b(f),    .sel(sel[0]), .y(ef));
   student_mux16 u_gh   (.a(g),    .b(h),    .sel(sel[0]), .y(gh));
   student_mux16 u_abcd (.a(ab),   .b(cd),   .sel(sel[1]), .y(abcd));
   student_mux16 u_efgh (.a(ef),   .b(gh),   .sel(sel[1]), .y(efgh));
   student_mux16 u_top  (.a(abcd), .b(efgh), .sel(sel[2]), .y(y));
endmodule

module student_mux_arbiter8 #(
   parameter int NREQ  = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  lock,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic [WIDTH-1:0] data_c,
   input  logic [WIDTH-1:0] data_d,
   input  logic [WIDTH-1:0] data_e,
   input  logic [WIDTH-1:0] data_f,
   input  logic [WIDTH-1:0] data_g,
   input  logic [WIDTH-1:0] data_h,
   output logic [NREQ-1:0]  grant,
   output logic [NREQ-1:0]  ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_src
);
   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [2:0] sel;
   logic [2:0] ptr;

   // Scan from p downwards so the lowest offset (p+1) wins and p itself is last.
   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      pick = p;
      for (int k = 8; k >= 1; k--) begin
         idx = p + 3'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   function automatic logic [7:0] onehot(input logic [2:0] idx);
      onehot = 8'b1 << idx;
   endfunction

   logic [2:0] first_pick;
   logic [2:0] next_pick;
   logic [7:0] others;
   logic       hold_lock;

   assign first_pick = pick(req, ptr);
   assign next_pick  = pick(req, sel);
   assign others     = req & ~onehot(sel);

`ifdef BURST_LOCK_EN
   assign hold_lock = lock[sel] & req[sel];
`else
   logic lock_unused;
   assign lock_unused = ^lock;
   assign hold_lock   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= 3'd0;
         ptr       <= 3'd7;
         grant     <= '0;
         out_valid <= 1'b0;
      end else if (state == IDLE) begin
         if (|req) begin
            sel       <= first_pick;
            grant     <= onehot(first_pick);
            out_valid <= 1'b1;
            state     <= GRANT;
         end
      end else begin
         if (out_ready) begin
            if (!hold_lock) begin
               ptr <= sel;
               if (|others) begin
                  sel   <= next_pick;
                  grant <= onehot(next_pick);
               end else if (!req[sel]) begin
                  grant     <= '0;
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
         end else if (!req[sel]) begin
            // Withdrawn before the consumer took the word: drop it, keep rotation state.
            grant     <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
         end
      end
   end

   assign ack     = grant & {NREQ{out_ready}};
   assign out_src = sel;

   logic [15:0] mux_word;
   student_mux8way16 u_mux (
      .a(data_a), .b(data_b), .c(data_c), .d(data_d),
      .e(data_e), .f(data_f), .g(data_g), .h(data_h),
      .sel(sel), .y(mux_word)
   );

   student_and16 u_gate (.a(mux_word), .b({16{out_valid}}), .y(out_data));
endmodule

// File: doc/student_mux_arbiter8.md
Name: student_mux_arbiter8

Overview:
- Round-robin arbiter that shares one 16-bit output bus among eight requesters.
- Selects the granted requester's data through an internal student_mux8way16. The select is driven by the registered grant index.
- Presents the selected word downstream with a valid/ready handshake and acknowledges the winning requester.
- Sits between multiple word producers (register-file ports, memory readers, I/O) and a single shared consumer.

Parameters:
- NREQ, 8, number of requesters. Fixed at 8 to match the 3-bit select of student_mux8way16; other values are unsupported.
- WIDTH, 16, data width. Fixed at 16 to match student_mux16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  8  request per requester, bit i = requester i
- lock  input  8  burst-hold request per requester; used only when BURST_LOCK_EN is defined, otherwise ignored
- data_a..data_h  input  16 each  requester data words, a = index 0 … h = index 7
- grant  output  8  one-hot registered grant, all-zero when idle
- ack  output  8  one-hot transfer pulse, combinational: grant & {8{out_ready}}
- out_valid  output  1  registered, high in GRANT state
- out_ready  input  1  consumer ready
- out_data  output  16  student_mux8way16(data_a..data_h, sel), forced to 0 when out_valid=0
- out_src  output  3  registered grant index (sel)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, sel=0, ptr=7, grant=0, out_valid=0.
  - Resulting outputs: out_src=0, out_data=0, ack=0.
  - Reset mid-transfer aborts with no ack; the in-flight word is dropped.
- Arbitration function pick(req, ptr):
  - Returns the first set bit scanning ptr+1, ptr+2, … mod 8, wrapping through ptr itself last.
  - Consequence: the last-served requester has lowest priority.
- State IDLE:
  - If req≠0: sel←pick, grant←onehot(pick), out_valid←1, state←GRANT.
  - Else remain IDLE.
  - Latency from req rising to out_valid is 1 cycle.
- State GRANT:
  - Transfer occurs when out_valid & out_ready; ack[sel]=1 in that same cycle.
  - On transfer: ptr←sel.
    - If (req with bit sel cleared)≠0: re-arbitrate immediately using ptr=sel, update sel/grant, stay in GRANT. No bubble, so back-to-back throughput is 1 word/cycle.
    - Else if req[sel] is still set: re-grant the same requester, stay in GRANT.
    - Else: grant←0, out_valid←0, state←IDLE.
  - No transfer and req[sel]=1: hold sel, grant and out_valid. A granted requester is never preempted while waiting on out_ready.
  - No transfer and req[sel]=0 (requester withdrew): grant←0, out_valid←0, state←IDLE. ptr is unchanged and no ack is issued.
- Requester contract:
  - Hold req and data stable until ack.
  - Deassert req the cycle after ack unless another word is ready.
- out_data is combinational from the live data inputs through the mux. It is zero-gated by out_valid using student gates, with no built-in mux.
- Simultaneous requests: exactly one grant per cycle; grant is always one-hot or zero.
- Wrap-around: ptr=7 gives priority order 0,1,…,7; ptr=3 gives 4,5,6,7,0,1,2,3.

Optional Feature:
- Macro: BURST_LOCK_EN.
- Defined:
  - On a transfer with lock[sel]=1 and req[sel]=1, the arbiter re-grants sel and leaves ptr unchanged, whatever other requests are pending.
  - The lock is released on the first transfer where lock[sel]=0; normal rotation then resumes from sel.
  - lock bits for non-granted requesters are ignored.
- Undefined: the lock input is unused and has no effect on behaviour. The port stays present.

Test Plan:
- Reset with req=8'hFF and rst_n=0 for 2 cycles -> grant=0, out_valid=0, out_data=0. Release reset -> next cycle grant=8'h01, out_src=0, out_data=data_a.
- req=8'hFF held, out_ready=1, data_x=16'h1000+i -> ack sequence idx 0,1,2,…,7,0 on consecutive cycles, out_data 16'h1000…16'h1007, no idle cycles.
- Only req[5]=1, out_ready=0 for 4 cycles, then 1 -> grant=8'h20 steady, out_data=data_f held, exactly one ack[5] pulse, then IDLE if req[5] drops.
- Granted requester 2 drops req before out_ready -> next cycle out_valid=0, no ack. With req[6]=1 pending -> grant=8'h40 one cycle later.
- After serving idx 3, req=8'h09 (0 and 3) -> next grant is idx 0 (wrap past 7), then idx 3.
- BURST_LOCK_EN defined: req=8'h03, lock[0]=1 for 3 transfers, other requests pending -> ack[0] ×3, then lock[0]=0 on a transfer -> next grant idx 1.
